// File: rtl/conv_pkg.sv
// Shared types and constants for the streaming 3x3 convolution engine.
// Taps are numbered in raster order: 0 = top-left, 4 = centre, 8 = bottom-right.
package conv_pkg;

    typedef enum logic [1:0] {
        MODE_GREY   = 2'd0,
        MODE_VSOBEL = 2'd1,
        MODE_HSOBEL = 2'd2,
        MODE_PROG   = 2'd3
    } mode_e;

    localparam int NUM_TAPS   = 9;
    localparam int TAP_CENTRE = 4;
    localparam int KERN_W     = 4;

    localparam logic signed [KERN_W-1:0] VSOBEL_K [NUM_TAPS] = '{
        -4'sd1, 4'sd0, 4'sd1,
        -4'sd2, 4'sd0, 4'sd2,
        -4'sd1, 4'sd0, 4'sd1
    };

    localparam logic signed [KERN_W-1:0] HSOBEL_K [NUM_TAPS] = '{
        -4'sd1, -4'sd2, -4'sd1,
         4'sd0,  4'sd0,  4'sd0,
         4'sd1,  4'sd2,  4'sd1
    };

endpackage

// File: rtl/conv_line_buffer.sv
// Two cascaded line-deep delay lines sharing one column address: row1_o is the
// pixel one line above the current one, row2_o the pixel two lines above.
module conv_line_buffer #(
    parameter int DATA_W = 12,
    parameter int LINE_W = 640,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              en_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] din_i,
    output logic [DATA_W-1:0] row1_o,
    output logic [DATA_W-1:0] row2_o
);

    logic [DATA_W-1:0] mem1_q [LINE_W];
    logic [DATA_W-1:0] mem2_q [LINE_W];

    assign row1_o = mem1_q[addr_i];
    assign row2_o = mem2_q[addr_i];

    // Contents are never reset; stale lines are masked by the row gating upstream.
    always_ff @(posedge clk) begin
        if (en_i) begin
            mem1_q[addr_i] <= din_i;
            mem2_q[addr_i] <= mem1_q[addr_i];
        end
    end

endmodule

// File: rtl/conv3x3_stream.sv
// Streaming 3x3 convolution over raster-ordered multi-channel pixels:
// greyscale, vertical/horizontal Sobel or a loadable kernel, |acc| clamped.
module conv3x3_stream
    import conv_pkg::*;
#(
    parameter int DATA_W = 12,
    parameter int NUM_CH = 3,
    parameter int LINE_W = 640,
    parameter int COEF_W = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH*DATA_W-1:0] ipix,
    input  logic                     idval,
    input  logic                     isof,
    input  logic [1:0]               mode,
    input  logic                     coef_we,
    input  logic [3:0]               coef_addr,
    input  logic signed [COEF_W-1:0] coef_data,
    output logic [NUM_CH*DATA_W-1:0] opix,
    output logic                     odval,
    output logic                     osof
);

    localparam int COL_W = $clog2(LINE_W);
    localparam int ACC_W = DATA_W + COEF_W + 4;

    logic [COL_W-1:0]         col_q, col_d, cur_col;
    logic [15:0]              row_q, row_d, cur_row;
    mode_e                    mode_q;
    logic signed [COEF_W-1:0] coef_q [NUM_TAPS];
    logic [DATA_W-1:0]        lb1 [NUM_CH];
    logic [DATA_W-1:0]        lb2 [NUM_CH];
    logic [DATA_W-1:0]        win_q [NUM_CH][NUM_TAPS];
    logic                     vld_p0_q, sof_p0_q;
    logic signed [COEF_W-1:0] k_w [NUM_TAPS];
    logic [DATA_W-1:0]        grey_w [NUM_CH];
    logic signed [ACC_W-1:0]  acc_d [NUM_CH];
    logic signed [ACC_W-1:0]  acc_p1_q [NUM_CH];
    logic                     vld_p1_q, sof_p1_q;
    logic [NUM_CH*DATA_W-1:0] opix_q;
    logic                     odval_q, osof_q;

    function automatic logic signed [ACC_W-1:0] tap_mul(input logic signed [COEF_W-1:0] k,
                                                        input logic [DATA_W-1:0] p);
        logic signed [ACC_W-1:0] ks;
        logic signed [ACC_W-1:0] ps;
        ks = ACC_W'(k);
        ps = ACC_W'(p);
        return ks * ps;
    endfunction

    function automatic logic [DATA_W-1:0] abs_clamp(input logic signed [ACC_W-1:0] a);
        logic [ACC_W-1:0] mag;
        mag = a[ACC_W-1] ? $unsigned(-a) : $unsigned(a);
        return (|mag[ACC_W-1:DATA_W]) ? '1 : mag[DATA_W-1:0];
    endfunction

    // An isof-qualified pixel is (0,0) wherever the counters happened to be.
    always_comb begin
        cur_col = isof ? '0 : col_q;
        cur_row = isof ? '0 : row_q;
        col_d   = col_q;
        row_d   = row_q;
        if (idval) begin
            if (cur_col == COL_W'(LINE_W - 1)) begin
                col_d = '0;
                row_d = (cur_row == 16'hFFFF) ? cur_row : cur_row + 16'd1;
            end else begin
                col_d = cur_col + COL_W'(1);
                row_d = cur_row;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q  <= '0;
            row_q  <= '0;
            mode_q <= MODE_GREY;
            for (int t = 0; t < NUM_TAPS; t++) coef_q[t] <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
            if (idval && isof) mode_q <= mode_e'(mode);
            if (coef_we && (coef_addr < 4'(NUM_TAPS))) coef_q[coef_addr] <= coef_data;
        end
    end

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_lb
        conv_line_buffer #(
            .DATA_W (DATA_W),
            .LINE_W (LINE_W),
            .ADDR_W (COL_W)
        ) u_lb (
            .clk    (clk),
            .en_i   (idval),
            .addr_i (cur_col),
            .din_i  (ipix[ch*DATA_W +: DATA_W]),
            .row1_o (lb1[ch]),
            .row2_o (lb2[ch])
        );
    end

    // ---- stage p0: window shift on accept ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0_q <= 1'b0;
            sof_p0_q <= 1'b0;
            for (int ch = 0; ch < NUM_CH; ch++)
                for (int t = 0; t < NUM_TAPS; t++) win_q[ch][t] <= '0;
        end else begin
            vld_p0_q <= idval && (cur_row >= 16'd2) && (cur_col >= COL_W'(2));
            sof_p0_q <= idval && (cur_row == 16'd2) && (cur_col == COL_W'(2));
            if (idval) begin
                for (int ch = 0; ch < NUM_CH; ch++) begin
                    for (int r = 0; r < 3; r++) begin
                        win_q[ch][3*r]   <= win_q[ch][3*r+1];
                        win_q[ch][3*r+1] <= win_q[ch][3*r+2];
                    end
                    win_q[ch][2] <= lb2[ch];
                    win_q[ch][5] <= lb1[ch];
                    win_q[ch][8] <= ipix[ch*DATA_W +: DATA_W];
                end
            end
        end
    end

    if (NUM_CH == 3) begin : g_grey_rgb
        logic [DATA_W+1:0] gsum;
        assign gsum = (DATA_W+2)'(win_q[0][TAP_CENTRE])
                    + ((DATA_W+2)'(win_q[1][TAP_CENTRE]) << 1)
                    + (DATA_W+2)'(win_q[2][TAP_CENTRE]);
        for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
            assign grey_w[ch] = DATA_W'(gsum >> 2);
        end
    end else begin : g_grey_pass
        for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
            assign grey_w[ch] = win_q[ch][TAP_CENTRE];
        end
    end

    always_comb begin
        for (int t = 0; t < NUM_TAPS; t++) begin
            k_w[t] = '0;
            case (mode_q)
                MODE_VSOBEL: k_w[t] = COEF_W'(VSOBEL_K[t]);
                MODE_HSOBEL: k_w[t] = COEF_W'(HSOBEL_K[t]);
                MODE_PROG:   k_w[t] = coef_q[t];
                default:     k_w[t] = '0;
            endcase
        end
    end

    // Greyscale rides the accumulator path as a non-negative value.
    always_comb begin
        for (int ch = 0; ch < NUM_CH; ch++) begin
            acc_d[ch] = '0;
            if (mode_q == MODE_GREY) begin
                acc_d[ch] = ACC_W'(grey_w[ch]);
            end else begin
                for (int t = 0; t < NUM_TAPS; t++)
                    acc_d[ch] = acc_d[ch] + tap_mul(k_w[t], win_q[ch][t]);
            end
        end
    end

    // ---- stage p1: MAC register; stage p2: abs/clamp output register ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1_q <= 1'b0;
            sof_p1_q <= 1'b0;
            for (int ch = 0; ch < NUM_CH; ch++) acc_p1_q[ch] <= '0;
            odval_q  <= 1'b0;
            osof_q   <= 1'b0;
            opix_q   <= '0;
        end else begin
            vld_p1_q <= vld_p0_q;
            sof_p1_q <= sof_p0_q;
            for (int ch = 0; ch < NUM_CH; ch++) acc_p1_q[ch] <= acc_d[ch];
            odval_q  <= vld_p1_q;
            osof_q   <= sof_p1_q;
            if (vld_p1_q) begin
                for (int ch = 0; ch < NUM_CH; ch++)
                    opix_q[ch*DATA_W +: DATA_W] <= abs_clamp(acc_p1_q[ch]);
            end
        end
    end

    assign opix  = opix_q;
    assign odval = odval_q;
    assign osof  = osof_q;

endmodule

// File: tb/tb_conv3x3_stream.sv
// Directed bench for conv3x3_stream with LINE_W=8: each output is checked for
// value, osof and exact arrival cycle (accept + 2 edges), bubbles checked as idle.
module tb_conv3x3_stream;

    localparam int DW = 12;
    localparam int NC = 3;
    localparam int LW = 8;
    localparam int CW = 4;
    localparam int PW = NC * DW;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [PW-1:0]        ipix;
    logic                 idval;
    logic                 isof;
    logic [1:0]           mode;
    logic                 coef_we;
    logic [3:0]           coef_addr;
    logic signed [CW-1:0] coef_data;
    logic [PW-1:0]        opix;
    logic                 odval;
    logic                 osof;

    conv3x3_stream #(
        .DATA_W (DW),
        .NUM_CH (NC),
        .LINE_W (LW),
        .COEF_W (CW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ipix      (ipix),
        .idval     (idval),
        .isof      (isof),
        .mode      (mode),
        .coef_we   (coef_we),
        .coef_addr (coef_addr),
        .coef_data (coef_data),
        .opix      (opix),
        .odval     (odval),
        .osof      (osof)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [PW-1:0] pix;
        logic        sof;
    } exp_t;

    exp_t          q[$];
    logic [PW-1:0] fr [4][LW];
    logic [PW-1:0] ex [4][LW];
    int            cyc_n = 0;
    int            n_vec = 0;
    int            n_err = 0;
    int            n_out = 0;

    function automatic logic [PW-1:0] all3(input logic [DW-1:0] v);
        return {v, v, v};
    endfunction

    task automatic check(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] req);
        n_vec++;
        assert (obs === req) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, req);
        end
    endtask

    // One clock; outputs sampled 1 time unit after the rising edge.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        cyc_n++;
        if (odval === 1'b1) n_out++;
        if (q.size() > 0 && q[0].due == cyc_n) begin
            e = q.pop_front();
            check("odval/osof", PW'({odval, osof}), PW'({1'b1, e.sof}));
            check("opix", opix, e.pix);
        end else begin
            check("idle odval/osof", PW'({odval, osof}), '0);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send_px(input int r, input int c, input bit sof);
        ipix  = fr[r][c];
        idval = 1'b1;
        isof  = sof;
        if (r >= 2 && c >= 2)
            q.push_back('{due: cyc_n + 3, pix: ex[r-1][c-1], sof: (r == 2 && c == 2)});
        tick();
        idval = 1'b0;
        isof  = 1'b0;
    endtask

    task automatic send_frame(input int rows);
        for (int r = 0; r < rows; r++)
            for (int c = 0; c < LW; c++) send_px(r, c, (r == 0 && c == 0));
    endtask

    task automatic write_coef(input int addr, input int val);
        coef_we   = 1'b1;
        coef_addr = 4'(addr);
        coef_data = CW'(val);
        tick();
        coef_we   = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; ipix = '0; idval = 1'b0; isof = 1'b0; mode = 2'd0;
        coef_we = 1'b0; coef_addr = '0; coef_data = '0;

        // reset state
        idle(2);
        check("reset opix", opix, '0);
        rst_n = 1'b1;
        idle(2);

        // vertical Sobel on a vertical edge between cols 3 and 4
        mode = 2'd1;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < LW; c++) begin
                fr[r][c] = (c < 4) ? all3(12'hFFF) : '0;
                ex[r][c] = (c == 3 || c == 4) ? all3(12'hFFF) : '0;
            end
        n_out = 0;
        send_frame(4);
        idle(4);
        check("vsobel count", PW'(n_out), PW'(12));

        // horizontal Sobel; mode switched mid-frame must not take effect
        mode = 2'd2;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < LW; c++) begin
                fr[r][c] = (r < 2) ? all3(12'hFFF) : '0;
                ex[r][c] = all3(12'hFFF);
            end
        n_out = 0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < LW; c++) begin
                if (r == 2 && c == 0) mode = 2'd1;
                send_px(r, c, (r == 0 && c == 0));
            end
        idle(4);
        check("hsobel count", PW'(n_out), PW'(12));

        // next isof picks up the vertical kernel: row-uniform image -> 0
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < LW; c++) ex[r][c] = '0;
        n_out = 0;
        send_frame(3);
        idle(4);
        check("mode latch count", PW'(n_out), PW'(6));

        // programmable: centre-only kernel passes the centre pixel through
        write_coef(4, 1);
        mode = 2'd3;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < LW; c++) begin
                fr[r][c] = PW'({$urandom, $urandom});
                ex[r][c] = fr[r][c];
            end
        n_out = 0;
        send_frame(4);
        idle(4);
        check("prog identity count", PW'(n_out), PW'(12));

        // all taps -8 on full-scale input: large negative sum -> abs and clamp
        for (int t = 0; t < 9; t++) write_coef(t, -8);
        write_coef(12, 7);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < LW; c++) begin
                fr[r][c] = all3(12'hFFF);
                ex[r][c] = all3(12'hFFF);
            end
        n_out = 0;
        send_frame(3);
        idle(4);
        check("prog clamp count", PW'(n_out), PW'(6));

        // greyscale: (0x400 + 2*0x800 + 0xC00) >> 2 = 0x800
        mode = 2'd0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < LW; c++) begin
                fr[r][c] = {12'hC00, 12'h800, 12'h400};
                ex[r][c] = all3(12'h800);
            end
        n_out = 0;
        send_frame(3);
        idle(4);
        check("grey count", PW'(n_out), PW'(6));

        // greyscale with random idle gaps; equal channels make grey == v
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < LW; c++) begin
                fr[r][c] = all3(DW'(r * 16 + c + 1));
                ex[r][c] = fr[r][c];
            end
        n_out = 0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < LW; c++) begin
                send_px(r, c, (r == 0 && c == 0));
                idle($urandom_range(0, 2));
            end
        idle(4);
        check("bubble count", PW'(n_out), PW'(12));

        // isof at (2,5) abandons the frame and restarts the counters
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < LW; c++) begin
                fr[r][c] = all3(DW'(12'h100 + r * 16 + c));
                ex[r][c] = fr[r][c];
            end
        n_out = 0;
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < LW; c++) send_px(r, c, (r == 0 && c == 0));
        for (int c = 0; c < 5; c++) send_px(2, c, 1'b0);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < LW; c++) begin
                fr[r][c] = all3(DW'(12'h300 + r * 16 + c));
                ex[r][c] = fr[r][c];
            end
        send_frame(3);
        idle(4);
        check("resync count", PW'(n_out), PW'(9));

        // asynchronous reset while an output is being presented
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < LW; c++) send_px(r, c, (r == 0 && c == 0));
        for (int c = 0; c < 5; c++) send_px(2, c, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset odval/osof", PW'({odval, osof}), '0);
        check("async reset opix", opix, '0);
        q.delete();
        idle(2);
        rst_n = 1'b1;
        n_out = 0;
        for (int c = 0; c < LW; c++) send_px(0, c, 1'b0);
        send_frame(3);
        idle(4);
        check("post-reset count", PW'(n_out), PW'(6));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
